// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings plus the subordinate interface FSM state codes.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ERR1   = 2'd2;
  localparam logic [1:0] ST_ERR2   = 2'd3;

endpackage

// File: rtl/ahb_wait_timer.sv
// Loadable/clearable saturating counter; term_out flags the cycle in which
// the count reaches MAX (combinational on the next value).
module ahb_wait_timer #(
  parameter int MAX = 6,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         ahb_clk_in,
  input  logic         ahb_rstn_in,
  input  logic         clr_in,
  input  logic         load_in,
  input  logic [W-1:0] load_val_in,
  input  logic         inc_in,
  output logic         term_out
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in)                           cnt_d = '0;
    else if (load_in)                     cnt_d = load_val_in;
    else if (inc_in && cnt_q != W'(MAX))  cnt_d = cnt_q + W'(1);
  end

  assign term_out = (cnt_d == W'(MAX));

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite subordinate: turns accepted NONSEQ/SEQ transfers into single
// valid/ready requests, with wait states, two-cycle ERROR and a wait timeout.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH   = 32,
  parameter int AHB_DATA_WIDTH   = 32,
  parameter int AHB_WAIT_TIMEOUT = 6
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic                      ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic                      ahb_write_in,
  input  logic [2:0]                ahb_size_in,
  input  logic [2:0]                ahb_burst_in,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
  input  logic                      ahb_ready_in,
  output logic                      ahb_readyout_out,
  output logic                      ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
  output logic                      other_valid_out,
  output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
  output logic                      other_write_out,
  output logic [2:0]                other_size_out,
  output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
  input  logic                      other_ready_in,
  input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in,
  input  logic                      other_error_in
);

  localparam int TW = $clog2(AHB_WAIT_TIMEOUT + 1);

  logic [1:0]                state_q, state_d;
  logic                      valid_q, valid_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [2:0]                size_q, size_d;
  logic                      readyout_q, readyout_d;
  logic                      resp_q, resp_d;
  logic [AHB_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                      accept, legal, too_wide;
  logic [AHB_ADDR_WIDTH-1:0] align_mask;
  logic                      tmr_clr, tmr_inc, tmr_term;
  logic                      unused_burst;

  // HBURST carries no behaviour here; bursts are served beat by beat.
  assign unused_burst = (ahb_burst_in == HBURST_INCR16);

  assign accept     = ahb_sel_in && ahb_ready_in &&
                      (ahb_trans_in == HTRANS_NONSEQ || ahb_trans_in == HTRANS_SEQ);
  assign too_wide   = (32'd8 << ahb_size_in) > 32'(AHB_DATA_WIDTH);
  assign align_mask = (AHB_ADDR_WIDTH'(1) << ahb_size_in) - AHB_ADDR_WIDTH'(1);
  assign legal      = !too_wide && ((ahb_addr_in & align_mask) == '0);

  ahb_wait_timer #(.MAX(AHB_WAIT_TIMEOUT), .W(TW)) u_timer (
    .ahb_clk_in  (ahb_clk_in),
    .ahb_rstn_in (ahb_rstn_in),
    .clr_in      (tmr_clr),
    .load_in     (1'b0),
    .load_val_in ('0),
    .inc_in      (tmr_inc),
    .term_out    (tmr_term)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    readyout_d = readyout_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        if (other_ready_in) begin
          valid_d = 1'b0;
          if (other_error_in) begin
            readyout_d = 1'b0;
            resp_d     = HRESP_ERROR;
            state_d    = ST_ERR1;
          end else begin
            readyout_d = 1'b1;
            resp_d     = HRESP_OKAY;
            rdata_d    = write_q ? '0 : other_rdata_in;
            state_d    = ST_IDLE;
          end
        end else begin
          tmr_inc = 1'b1;
          // Timeout abandons the request; a late ready lands in ERR1 and is ignored.
          if (tmr_term) begin
            valid_d    = 1'b0;
            readyout_d = 1'b0;
            resp_d     = HRESP_ERROR;
            state_d    = ST_ERR1;
          end
        end
      end
      ST_ERR1: begin
        readyout_d = 1'b1;
        resp_d     = HRESP_ERROR;
        state_d    = ST_ERR2;
      end
      default: begin
        if (accept && legal) begin
          addr_d     = ahb_addr_in;
          write_d    = ahb_write_in;
          size_d     = ahb_size_in;
          valid_d    = 1'b1;
          readyout_d = 1'b0;
          resp_d     = HRESP_OKAY;
          tmr_clr    = 1'b1;
          state_d    = ST_ACCESS;
        end else if (accept) begin
          readyout_d = 1'b0;
          resp_d     = HRESP_ERROR;
          state_d    = ST_ERR1;
        end else begin
          readyout_d = 1'b1;
          resp_d     = HRESP_OKAY;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      readyout_q <= 1'b1;
      resp_q     <= HRESP_OKAY;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
      readyout_q <= readyout_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ahb_readyout_out = readyout_q;
  assign ahb_resp_out     = resp_q;
  assign ahb_rdata_out    = rdata_q;
  assign other_valid_out  = valid_q;
  assign other_addr_out   = addr_q;
  assign other_write_out  = write_q;
  assign other_size_out   = size_q;
  assign other_wdata_out  = (valid_q && write_q) ? ahb_wdata_in : '0;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if on a single-slave bus (HREADY = HREADYOUT).
module tb_ahb_slave_if;
  import ahb_pkg::*;

  logic        gclk = 1'b0;
  logic        rstn;
  logic        sel, write, oready, oerror;
  logic [31:0] addr, wdata, ordata;
  logic [1:0]  trans;
  logic [2:0]  size, burst;
  logic        readyout, resp, ovalid, owrite, hready;
  logic [31:0] rdata, oaddr, owdata;
  logic [2:0]  osize;

  int checks   = 0;
  int failures = 0;

  assign hready = readyout;

  ahb_slave_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .AHB_WAIT_TIMEOUT(6)) dut (
    .ahb_clk_in       (gclk),
    .ahb_rstn_in      (rstn),
    .ahb_sel_in       (sel),
    .ahb_addr_in      (addr),
    .ahb_trans_in     (trans),
    .ahb_write_in     (write),
    .ahb_size_in      (size),
    .ahb_burst_in     (burst),
    .ahb_wdata_in     (wdata),
    .ahb_ready_in     (hready),
    .ahb_readyout_out (readyout),
    .ahb_resp_out     (resp),
    .ahb_rdata_out    (rdata),
    .other_valid_out  (ovalid),
    .other_addr_out   (oaddr),
    .other_write_out  (owrite),
    .other_size_out   (osize),
    .other_wdata_out  (owdata),
    .other_ready_in   (oready),
    .other_rdata_in   (ordata),
    .other_error_in   (oerror)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; registered outputs are settled.
  task automatic cyc();
    @(posedge gclk);
    #1;
  endtask

  task automatic addr_phase(input logic [1:0] t, input logic [31:0] a,
                            input logic w, input logic [2:0] s);
    sel = 1'b1; trans = t; addr = a; write = w; size = s;
  endtask

  task automatic bus_idle();
    sel = 1'b0; trans = HTRANS_IDLE;
  endtask

  initial begin
    rstn = 1'b0; sel = 1'b0; addr = '0; trans = HTRANS_IDLE; write = 1'b0;
    size = 3'd0; burst = HBURST_SINGLE; wdata = '0; oready = 1'b0;
    ordata = '0; oerror = 1'b0;
    repeat (3) @(posedge gclk);
    #2;
    chk("rst_readyout", 64'(readyout), 64'd1);
    chk("rst_resp",     64'(resp),     64'd0);
    chk("rst_rdata",    64'(rdata),    64'd0);
    chk("rst_valid",    64'(ovalid),   64'd0);
    chk("rst_addr",     64'(oaddr),    64'd0);
    chk("rst_write",    64'(owrite),   64'd0);
    chk("rst_size",     64'(osize),    64'd0);
    rstn = 1'b1;

    // Single write, local ready on first valid cycle.
    cyc();
    addr_phase(HTRANS_NONSEQ, 32'h10, 1'b1, 3'd2);
    cyc();
    bus_idle(); wdata = 32'hA5A5_0001; oready = 1'b1; #1;
    chk("wr_valid",    64'(ovalid),   64'd1);
    chk("wr_addr",     64'(oaddr),    64'h10);
    chk("wr_dir",      64'(owrite),   64'd1);
    chk("wr_size",     64'(osize),    64'd2);
    chk("wr_wdata",    64'(owdata),   64'hA5A5_0001);
    chk("wr_readyout", 64'(readyout), 64'd0);
    chk("wr_resp",     64'(resp),     64'd0);
    cyc();
    oready = 1'b0; #1;
    chk("wr_done_valid", 64'(ovalid),   64'd0);
    chk("wr_done_ready", 64'(readyout), 64'd1);
    chk("wr_done_resp",  64'(resp),     64'd0);
    chk("wr_done_wdata", 64'(owdata),   64'd0);

    // Read with three wait states.
    addr_phase(HTRANS_NONSEQ, 32'h20, 1'b0, 3'd2);
    cyc();
    bus_idle(); ordata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      oready = (k == 2);
      #1;
      chk($sformatf("rd_wait%0d_readyout", k), 64'(readyout), 64'd0);
      chk($sformatf("rd_wait%0d_valid", k),    64'(ovalid),   64'd1);
      cyc();
    end
    oready = 1'b0; #1;
    chk("rd_done_ready", 64'(readyout), 64'd1);
    chk("rd_done_resp",  64'(resp),     64'd0);
    chk("rd_done_rdata", 64'(rdata),    64'hDEAD_BEEF);
    chk("rd_done_valid", 64'(ovalid),   64'd0);

    // Illegal transfers: oversize and misaligned.
    for (int n = 0; n < 2; n++) begin
      if (n == 0) addr_phase(HTRANS_NONSEQ, 32'h0, 1'b0, 3'd3);
      else        addr_phase(HTRANS_NONSEQ, 32'h2, 1'b0, 3'd2);
      cyc();
      bus_idle(); #1;
      chk($sformatf("ill%0d_e1_valid", n), 64'(ovalid),   64'd0);
      chk($sformatf("ill%0d_e1_ready", n), 64'(readyout), 64'd0);
      chk($sformatf("ill%0d_e1_resp", n),  64'(resp),     64'd1);
      cyc();
      chk($sformatf("ill%0d_e2_valid", n), 64'(ovalid),   64'd0);
      chk($sformatf("ill%0d_e2_ready", n), 64'(readyout), 64'd1);
      chk($sformatf("ill%0d_e2_resp", n),  64'(resp),     64'd1);
      cyc();
      chk($sformatf("ill%0d_idle_resp", n), 64'(resp),    64'd0);
    end

    // Local error, then a NONSEQ pipelined into ERR2.
    addr_phase(HTRANS_NONSEQ, 32'h30, 1'b0, 3'd2);
    cyc();
    bus_idle(); oready = 1'b1; oerror = 1'b1;
    cyc();
    oready = 1'b0; oerror = 1'b0; #1;
    chk("lerr_e1_valid", 64'(ovalid),   64'd0);
    chk("lerr_e1_ready", 64'(readyout), 64'd0);
    chk("lerr_e1_resp",  64'(resp),     64'd1);
    cyc();
    chk("lerr_e2_ready", 64'(readyout), 64'd1);
    chk("lerr_e2_resp",  64'(resp),     64'd1);
    addr_phase(HTRANS_NONSEQ, 32'h34, 1'b0, 3'd2);
    cyc();
    bus_idle(); oready = 1'b1; ordata = 32'h1234_5678; #1;
    chk("pipe_valid", 64'(ovalid),   64'd1);
    chk("pipe_addr",  64'(oaddr),    64'h34);
    chk("pipe_ready", 64'(readyout), 64'd0);
    chk("pipe_resp",  64'(resp),     64'd0);
    cyc();
    oready = 1'b0; #1;
    chk("pipe_done_ready", 64'(readyout), 64'd1);
    chk("pipe_done_resp",  64'(resp),     64'd0);
    chk("pipe_done_rdata", 64'(rdata),    64'h1234_5678);

    // Timeout: six valid cycles, then ERROR; late ready ignored.
    addr_phase(HTRANS_NONSEQ, 32'h40, 1'b0, 3'd2);
    cyc();
    bus_idle();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("to_wait%0d_valid", k), 64'(ovalid), 64'd1);
      cyc();
    end
    chk("to_e1_valid", 64'(ovalid),   64'd0);
    chk("to_e1_ready", 64'(readyout), 64'd0);
    chk("to_e1_resp",  64'(resp),     64'd1);
    oready = 1'b1; ordata = 32'h0000_0BAD;
    cyc();
    oready = 1'b0; #1;
    chk("to_e2_ready", 64'(readyout), 64'd1);
    chk("to_e2_resp",  64'(resp),     64'd1);
    chk("to_e2_rdata", 64'(rdata),    64'h1234_5678);
    cyc();
    chk("to_idle_ready", 64'(readyout), 64'd1);
    chk("to_idle_resp",  64'(resp),     64'd0);
    chk("to_idle_valid", 64'(ovalid),   64'd0);

    // INCR4 writes, zero-delay local side, BUSY after the first beat.
    burst = HBURST_INCR4; oready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      addr_phase(b == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 32'(b * 4), 1'b1, 3'd2);
      cyc();
      bus_idle(); wdata = 32'hC0DE_0000 + 32'(b); #1;
      chk($sformatf("b%0d_valid", b), 64'(ovalid), 64'd1);
      chk($sformatf("b%0d_addr", b),  64'(oaddr),  64'(b * 4));
      chk($sformatf("b%0d_wdata", b), 64'(owdata), 64'hC0DE_0000 + 64'(b));
      cyc();
      chk($sformatf("b%0d_done_ready", b), 64'(readyout), 64'd1);
      if (b == 0) begin
        sel = 1'b1; trans = HTRANS_BUSY; addr = 32'h4;
        cyc();
        chk("busy_ready", 64'(readyout), 64'd1);
        chk("busy_resp",  64'(resp),     64'd0);
        chk("busy_valid", 64'(ovalid),   64'd0);
      end
    end
    oready = 1'b0; burst = HBURST_SINGLE;

    // Asynchronous reset in the middle of an access.
    addr_phase(HTRANS_NONSEQ, 32'h50, 1'b0, 3'd2);
    cyc();
    bus_idle(); #1;
    chk("mid_valid_before", 64'(ovalid), 64'd1);
    rstn = 1'b0; #1;
    chk("mid_rst_valid", 64'(ovalid),   64'd0);
    chk("mid_rst_ready", 64'(readyout), 64'd1);
    chk("mid_rst_resp",  64'(resp),     64'd0);
    chk("mid_rst_addr",  64'(oaddr),    64'd0);
    chk("mid_rst_rdata", 64'(rdata),    64'd0);
    chk("mid_rst_size",  64'(osize),    64'd0);
    cyc();
    rstn = 1'b1;
    cyc();
    chk("post_rst_valid", 64'(ovalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
